// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared command codes and state types for the GPU memory arbiter
package gpu_mem_pkg;

    localparam logic [1:0] CMD_8BYTE  = 2'd0;
    localparam logic [1:0] CMD_32BYTE = 2'd1;
    localparam logic [1:0] CMD_4BYTE  = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        DRAW = 2'd2
    } owner_t;

endpackage

// File: rtl/gpu_mem_arb_prio.sv
// rtl/gpu_mem_arb_prio.sv - display-priority grant decision with draw starvation counter
module gpu_mem_arb_prio
    import gpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_nRst,
    input  logic i_dispReq,
    input  logic i_drawReq,
    input  logic i_grantEn,
    output logic o_grantDisp,
    output logic o_grantDraw
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starveCnt;
    logic       drawWins;

    // Draw only overtakes a waiting display once display has had its quota in a row.
    assign drawWins    = i_drawReq && (!i_dispReq || (starveCnt == LIMIT));
    assign o_grantDraw = i_grantEn && drawWins;
    assign o_grantDisp = i_grantEn && i_dispReq && !drawWins;

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            starveCnt <= 3'd0;
        end else if (o_grantDraw) begin
            starveCnt <= 3'd0;
        end else if (o_grantDisp) begin
            if (!i_drawReq) begin
                starveCnt <= 3'd0;
            end else if (starveCnt < LIMIT) begin
                starveCnt <= starveCnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// rtl/gpu_mem_arbiter.sv - two-client display/draw arbiter in front of the DDR bridge port
module gpu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         i_clk,
    input  logic         i_nRst,
    input  logic         i_dispReq,
    input  logic [14:0]  i_dispAddr,
    output logic         o_dispAck,
    output logic         o_dispDataValid,
    input  logic         i_drawReq,
    input  logic         i_drawWrite,
    input  logic [1:0]   i_drawSize,
    input  logic [14:0]  i_drawAddr,
    input  logic [2:0]   i_drawSubAddr,
    input  logic [15:0]  i_drawMask,
    input  logic [255:0] i_drawData,
    output logic         o_drawAck,
    output logic         o_drawDataValid,
    output logic [255:0] o_rdData,
    output logic         o_command,
    output logic         o_writeElseRead,
    output logic [1:0]   o_commandSize,
    output logic [14:0]  o_targetAddr,
    output logic [2:0]   o_subAddr,
    output logic [15:0]  o_writeMask,
    output logic [255:0] o_dataClient,
    input  logic         i_busyClient,
    input  logic         i_dataValidClient,
    input  logic [255:0] i_dataClient,
    output logic         o_protoErr
);

    arb_state_t state, stateNext;
    owner_t     owner;
    logic       readPending;
    logic       protoErr;
    logic       grantEn, grantDisp, grantDraw;

    logic         cmdWrite;
    logic [1:0]   cmdSize;
    logic [14:0]  cmdAddr;
    logic [2:0]   cmdSub;
    logic [15:0]  cmdMask;
    logic [255:0] cmdData;

    // Reset gates the grant so no ack can leak out while the block is held in reset.
    assign grantEn = (state == ARB_IDLE) && !i_busyClient && i_nRst;

    gpu_mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .i_clk      (i_clk),
        .i_nRst     (i_nRst),
        .i_dispReq  (i_dispReq),
        .i_drawReq  (i_drawReq),
        .i_grantEn  (grantEn),
        .o_grantDisp(grantDisp),
        .o_grantDraw(grantDraw)
    );

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ARB_IDLE:  if (grantDisp || grantDraw) stateNext = ARB_ISSUE;
            ARB_ISSUE: stateNext = ARB_WAIT;
            ARB_WAIT:  if (!i_busyClient) stateNext = ARB_IDLE;
            default:   stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            owner       <= NONE;
            readPending <= 1'b0;
            protoErr    <= 1'b0;
            cmdWrite    <= 1'b0;
            cmdSize     <= 2'd0;
            cmdAddr     <= 15'd0;
            cmdSub      <= 3'd0;
            cmdMask     <= 16'd0;
            cmdData     <= 256'd0;
        end else begin
            if (grantDisp) begin
                owner       <= DISP;
                readPending <= 1'b1;
                cmdWrite    <= 1'b0;
                cmdSize     <= CMD_32BYTE;
                cmdAddr     <= i_dispAddr;
                cmdSub      <= 3'd0;
                cmdMask     <= 16'hFFFF;
                cmdData     <= 256'd0;
            end else if (grantDraw) begin
                owner       <= DRAW;
                readPending <= !i_drawWrite;
                cmdWrite    <= i_drawWrite;
                cmdSize     <= i_drawSize;
                cmdAddr     <= i_drawAddr;
                cmdSub      <= i_drawSubAddr;
                cmdMask     <= i_drawMask;
                cmdData     <= i_drawData;
            end else if (i_dataValidClient) begin
                readPending <= 1'b0;
            end
            if (i_dataValidClient && !readPending) begin
                protoErr <= 1'b1;
            end
        end
    end

    assign o_dispAck       = grantDisp;
    assign o_drawAck       = grantDraw;
    assign o_dispDataValid = i_dataValidClient && readPending && (owner == DISP);
    assign o_drawDataValid = i_dataValidClient && readPending && (owner == DRAW);
    assign o_rdData        = i_dataClient;
    assign o_command       = (state == ARB_ISSUE);
    assign o_writeElseRead = cmdWrite;
    assign o_commandSize   = cmdSize;
    assign o_targetAddr    = cmdAddr;
    assign o_subAddr       = cmdSub;
    assign o_writeMask     = cmdMask;
    assign o_dataClient    = cmdData;
    assign o_protoErr      = protoErr;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb/tb_gpu_mem_arbiter.sv - directed self-checking bench for gpu_mem_arbiter
module tb_gpu_mem_arbiter;
    import gpu_mem_pkg::*;

    logic         i_clk, i_nRst;
    logic         i_dispReq;
    logic [14:0]  i_dispAddr;
    logic         o_dispAck, o_dispDataValid;
    logic         i_drawReq, i_drawWrite;
    logic [1:0]   i_drawSize;
    logic [14:0]  i_drawAddr;
    logic [2:0]   i_drawSubAddr;
    logic [15:0]  i_drawMask;
    logic [255:0] i_drawData;
    logic         o_drawAck, o_drawDataValid;
    logic [255:0] o_rdData;
    logic         o_command, o_writeElseRead;
    logic [1:0]   o_commandSize;
    logic [14:0]  o_targetAddr;
    logic [2:0]   o_subAddr;
    logic [15:0]  o_writeMask;
    logic [255:0] o_dataClient;
    logic         i_busyClient, i_dataValidClient;
    logic [255:0] i_dataClient;
    logic         o_protoErr;

    logic         bBusy, bValid, bActive, spurValid;
    logic [255:0] bData, spurData, rdPattern, dispData, drawData, expData;
    int           busyLen;
    int           dispValidCnt, drawValidCnt, cmdCnt;
    bit           ackLog[$];
    int           checks, failures;
    int           base, dvBase, drBase, cmdBase, tmo;
    bit           expOrder[10];

    assign i_busyClient      = bBusy;
    assign i_dataValidClient = bValid | spurValid;
    assign i_dataClient      = bValid ? bData : spurData;

    gpu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_nRst(i_nRst),
        .i_dispReq(i_dispReq), .i_dispAddr(i_dispAddr),
        .o_dispAck(o_dispAck), .o_dispDataValid(o_dispDataValid),
        .i_drawReq(i_drawReq), .i_drawWrite(i_drawWrite), .i_drawSize(i_drawSize),
        .i_drawAddr(i_drawAddr), .i_drawSubAddr(i_drawSubAddr), .i_drawMask(i_drawMask),
        .i_drawData(i_drawData), .o_drawAck(o_drawAck), .o_drawDataValid(o_drawDataValid),
        .o_rdData(o_rdData), .o_command(o_command), .o_writeElseRead(o_writeElseRead),
        .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr), .o_subAddr(o_subAddr),
        .o_writeMask(o_writeMask), .o_dataClient(o_dataClient),
        .i_busyClient(i_busyClient), .i_dataValidClient(i_dataValidClient),
        .i_dataClient(i_dataClient), .o_protoErr(o_protoErr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Bridge model: busy from the cycle after the command, read data in the last busy cycle.
    initial begin
        bit isWrite, aborted;
        bBusy = 1'b0; bValid = 1'b0; bData = '0; bActive = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_nRst && o_command) begin
                isWrite = o_writeElseRead;
                bActive = 1'b1;
                @(posedge i_clk); #1;
                bBusy = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < busyLen - 1; k++) begin
                    @(posedge i_clk); #1;
                    if (!i_nRst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && !isWrite) begin
                    bValid = 1'b1;
                    bData  = rdPattern;
                end
                if (!aborted) begin
                    @(posedge i_clk); #1;
                end
                bValid = 1'b0; bData = '0; bBusy = 1'b0; bActive = 1'b0;
            end
        end
    end

    initial begin
        dispValidCnt = 0; drawValidCnt = 0; cmdCnt = 0;
        dispData = '0; drawData = '0;
        forever begin
            @(negedge i_clk);
            if (i_nRst) begin
                if (o_dispAck) ackLog.push_back(1'b0);
                if (o_drawAck) ackLog.push_back(1'b1);
                if (o_dispDataValid) begin dispValidCnt++; dispData = o_rdData; end
                if (o_drawDataValid) begin drawValidCnt++; drawData = o_rdData; end
                if (o_command) cmdCnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk); #1;
    endtask

    task automatic drive();
        @(posedge i_clk); #1;
    endtask

    task automatic waitBridge(input string tag);
        tmo = 0;
        while (bActive && tmo < 100) begin tick(); tmo++; end
        check(tag, 256'(tmo >= 100), 256'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        i_nRst = 1'b0; i_dispReq = 1'b0; i_dispAddr = '0;
        i_drawReq = 1'b0; i_drawWrite = 1'b0; i_drawSize = '0; i_drawAddr = '0;
        i_drawSubAddr = '0; i_drawMask = '0; i_drawData = '0;
        spurValid = 1'b0; spurData = '0; busyLen = 6;
        rdPattern = {8{32'hCAFE_0001}};
        expOrder = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        repeat (3) tick();
        check("rst_command", 256'(o_command), 256'd0);
        check("rst_fields", {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}, 256'd0);
        check("rst_protoErr", 256'(o_protoErr), 256'd0);
        i_nRst = 1'b1;
        repeat (2) tick();

        // Display-only read
        drive(); i_dispReq = 1'b1; i_dispAddr = 15'h1234;
        tick();  check("t1_dispAck", 256'(o_dispAck), 256'd1);
        check("t1_no_cmd_yet", 256'(o_command), 256'd0);
        drive(); i_dispReq = 1'b0;
        tick();
        check("t1_command", 256'(o_command), 256'd1);
        check("t1_fields", {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask},
              {1'b0, 2'd1, 15'h1234, 3'd0, 16'hFFFF});
        waitBridge("t1_timeout");
        repeat (2) tick();
        check("t1_dispValidCnt", 256'(dispValidCnt), 256'd1);
        check("t1_drawValidCnt", 256'(drawValidCnt), 256'd0);
        check("t1_dispData", dispData, rdPattern);
        check("t1_cmdCnt", 256'(cmdCnt), 256'd1);

        // Draw 4-byte write
        expData = {224'h0, 32'hDEADBEEF};
        drive(); i_drawReq = 1'b1; i_drawWrite = 1'b1; i_drawSize = CMD_4BYTE;
        i_drawAddr = 15'h0010; i_drawSubAddr = 3'd3; i_drawMask = 16'h000F; i_drawData = expData;
        tick();  check("t2_drawAck", 256'(o_drawAck), 256'd1);
        drive(); i_drawReq = 1'b0;
        tick();
        check("t2_command", 256'(o_command), 256'd1);
        check("t2_fields", {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask},
              {1'b1, 2'd2, 15'h0010, 3'd3, 16'h000F});
        check("t2_data", o_dataClient, expData);
        waitBridge("t2_timeout");
        tick();
        check("t2_idle", 256'(dut.state), 256'(ARB_IDLE));
        check("t2_noValid", 256'(dispValidCnt + drawValidCnt), 256'd1);

        // Both requesting continuously
        busyLen = 2;
        base = ackLog.size();
        drive(); i_dispReq = 1'b1; i_dispAddr = 15'h0100;
        i_drawReq = 1'b1; i_drawWrite = 1'b1; i_drawSize = CMD_8BYTE; i_drawAddr = 15'h0300;
        tmo = 0;
        while (ackLog.size() < base + 10 && tmo < 500) begin tick(); tmo++; end
        drive(); i_dispReq = 1'b0; i_drawReq = 1'b0;
        check("t3_timeout", 256'(tmo >= 500), 256'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_grant%0d", i), 256'(ackLog[base + i]), 256'(expOrder[i]));
        end
        tick();
        waitBridge("t3_drain");
        repeat (2) tick();
        check("t3_ackTotal", 256'(ackLog.size()), 256'(base + 10));

        // Draw read with display arriving mid-transaction
        busyLen = 8; rdPattern = {4{64'h0123_4567_89AB_CDEF}};
        dvBase = dispValidCnt; drBase = drawValidCnt; base = ackLog.size();
        drive(); i_drawReq = 1'b1; i_drawWrite = 1'b0; i_drawSize = CMD_32BYTE; i_drawAddr = 15'h0200;
        tick();  check("t4_drawAck", 256'(o_drawAck), 256'd1);
        drive(); i_drawReq = 1'b0;
        tick();  check("t4_cmdRead", {o_command, o_writeElseRead}, {1'b1, 1'b0});
        drive(); drive(); i_dispReq = 1'b1; i_dispAddr = 15'h0777;
        waitBridge("t4_timeout");
        check("t4_drawValid", 256'(drawValidCnt), 256'(drBase + 1));
        check("t4_dispNoValid", 256'(dispValidCnt), 256'(dvBase));
        check("t4_drawData", drawData, rdPattern);
        check("t4_noEarlyDisp", 256'(ackLog.size()), 256'(base + 1));
        tmo = 0;
        while (!o_dispAck && tmo < 10) begin tick(); tmo++; end
        check("t4_dispAckLate", 256'(o_dispAck), 256'd1);
        drive(); i_dispReq = 1'b0;
        tick();
        waitBridge("t4_drain");
        repeat (2) tick();
        check("t4_dispValid", 256'(dispValidCnt), 256'(dvBase + 1));

        // Spurious read data while idle
        check("t5_protoErr_before", 256'(o_protoErr), 256'd0);
        dvBase = dispValidCnt; drBase = drawValidCnt;
        drive(); spurValid = 1'b1; spurData = {8{32'h5A5A_1234}};
        tick();
        check("t5_noValids", {o_dispDataValid, o_drawDataValid}, 256'd0);
        check("t5_passthrough", o_rdData, {8{32'h5A5A_1234}});
        drive(); spurValid = 1'b0; spurData = '0;
        tick();  check("t5_protoErr", 256'(o_protoErr), 256'd1);
        repeat (4) tick();
        check("t5_protoErr_sticky", 256'(o_protoErr), 256'd1);

        // Reset in the wait phase of a read
        busyLen = 20; cmdBase = cmdCnt;
        drive(); i_dispReq = 1'b1; i_dispAddr = 15'h0042;
        tick();  check("t6_dispAck", 256'(o_dispAck), 256'd1);
        drive(); i_dispReq = 1'b0;
        tick();  check("t6_command", 256'(o_command), 256'd1);
        repeat (3) tick();
        check("t6_inWait", 256'(dut.state), 256'(ARB_WAIT));
        dvBase = dispValidCnt;
        i_nRst = 1'b0;
        #1;
        check("t6_rst_cmd", 256'(o_command), 256'd0);
        check("t6_rst_fields", {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}, 256'd0);
        check("t6_rst_protoErr", 256'(o_protoErr), 256'd0);
        check("t6_rst_valids", {o_dispAck, o_drawAck, o_dispDataValid, o_drawDataValid}, 256'd0);
        repeat (2) tick();
        i_nRst = 1'b1;
        repeat (30) tick();
        check("t6_noStaleValid", 256'(dispValidCnt), 256'(dvBase));
        check("t6_idle", 256'(dut.state), 256'(ARB_IDLE));
        check("t6_protoErr", 256'(o_protoErr), 256'd0);
        check("t6_noNewCmd", 256'(cmdCnt), 256'(cmdBase + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
